// File: rtl/db_pkg.sv
// Shared types and constants for the Otter debugger serial command decoder.
package db_pkg;

  typedef enum logic [3:0] {
    DB_OP_PAUSE  = 4'd1,
    DB_OP_RESUME = 4'd2,
    DB_OP_RESET  = 4'd3,
    DB_OP_MEM_RD = 4'd4,
    DB_OP_MEM_WR = 4'd5,
    DB_OP_REG_RD = 4'd6,
    DB_OP_REG_WR = 4'd7
  } db_op_e;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT,
    S_REPLY
  } db_state_e;

  localparam logic [7:0] DB_ACK = 8'hA5;
  localparam logic [7:0] DB_ERR = 8'hEE;

  localparam int unsigned DB_ADDR_BYTES  = 4;
  localparam int unsigned DB_DATA_BYTES  = 4;
  localparam int unsigned DB_RDATA_BYTES = 4;

  localparam logic [1:0] DB_LAST_BYTE = 2'(DB_ADDR_BYTES - 1);
  localparam logic [1:0] DB_RDATA_LEFT = 2'(DB_RDATA_BYTES - 1);

  function automatic logic db_cmd_legal(logic [7:0] cmd);
    return (cmd[7:6] == 2'b00) && (cmd[3:0] >= 4'd1) && (cmd[3:0] <= 4'd7);
  endfunction

  function automatic logic db_op_has_addr(db_op_e op);
    return op >= DB_OP_MEM_RD;
  endfunction

  function automatic logic db_op_has_data(db_op_e op);
    return (op == DB_OP_MEM_WR) || (op == DB_OP_REG_WR);
  endfunction

  function automatic logic db_op_has_rdata(db_op_e op);
    return (op == DB_OP_MEM_RD) || (op == DB_OP_REG_RD);
  endfunction

endpackage

// File: rtl/db_timeout_ctr.sv
// Down-counter watchdog: clear reloads Count, enable decrements, expired flags the last cycle.
module db_timeout_ctr #(
  parameter int unsigned Count = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned Width = $clog2(Count + 1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= Width'(Count);
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  // Fires in the Count-th enabled cycle after the last clear.
  assign expired = enable && (count_q == Width'(1));

endmodule

// File: rtl/db_cmd_decoder.sv
// UART byte stream to debug-adapter command front end with ack/error/read-data replies.
module db_cmd_decoder
  import db_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 50,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned BUSY_MAX   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        mcu_busy,
  input  logic [31:0] d_rd,
  output logic        valid,
  output logic        pause,
  output logic        resume,
  output logic        reset,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic        error
);

  db_state_e   state_q, state_d;
  db_op_e      op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] reply_q, reply_d;
  logic [1:0]  reply_left_q, reply_left_d;
  logic        wait_first_q;
  logic        error_q, error_d;
  logic        valid_q, valid_d;
  logic [6:0]  strobe_q, strobe_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        tx_valid_q, tx_valid_d;

  logic in_frame;
  logic byte_timeout;
  logic busy_timeout;

  assign in_frame = (state_q == S_ADDR) || (state_q == S_DATA);

  db_timeout_ctr #(
    .Count (CLK_RATE * TIMEOUT_US)
  ) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_frame || rx_valid),
    .enable  (in_frame),
    .expired (byte_timeout)
  );

  db_timeout_ctr #(
    .Count (BUSY_MAX)
  ) u_busy_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != S_WAIT),
    .enable  (state_q == S_WAIT),
    .expired (busy_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CMD;
      op_q         <= DB_OP_PAUSE;
      size_q       <= '0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      reply_q      <= '0;
      reply_left_q <= '0;
      wait_first_q <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      strobe_q     <= '0;
      mem_size_q   <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      size_q       <= size_d;
      byte_cnt_q   <= byte_cnt_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      reply_q      <= reply_d;
      reply_left_q <= reply_left_d;
      wait_first_q <= (state_q == S_ISSUE);
      error_q      <= error_d;
      valid_q      <= valid_d;
      strobe_q     <= strobe_d;
      mem_size_q   <= mem_size_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    byte_cnt_d   = byte_cnt_q;
    addr_d       = addr_q;
    din_d        = din_q;
    reply_d      = reply_q;
    reply_left_d = reply_left_q;
    error_d      = 1'b0;
    case (state_q)
      S_CMD: begin
        if (rx_valid) begin
          if (db_cmd_legal(rx_data)) begin
            op_d       = db_op_e'(rx_data[3:0]);
            size_d     = rx_data[5:4];
            byte_cnt_d = '0;
            state_d    = db_op_has_addr(op_d) ? S_ADDR : S_ISSUE;
          end else begin
            error_d      = 1'b1;
            reply_d      = {DB_ERR, 24'h0};
            reply_left_d = '0;
            state_d      = S_REPLY;
          end
        end
      end
      S_ADDR: begin
        // An arriving byte takes priority over a coincident timeout.
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == DB_LAST_BYTE) begin
            state_d = db_op_has_data(op_q) ? S_DATA : S_ISSUE;
          end
        end else if (byte_timeout) begin
          error_d    = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_CMD;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          din_d      = {din_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == DB_LAST_BYTE) begin
            state_d = S_ISSUE;
          end
        end else if (byte_timeout) begin
          error_d    = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_CMD;
        end
      end
      S_ISSUE: begin
        error_d = rx_valid;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        error_d = rx_valid;
        // mcu_busy may not have risen yet in the first wait cycle.
        if (!wait_first_q && !mcu_busy) begin
          state_d = S_REPLY;
          if (db_op_has_rdata(op_q)) begin
            reply_d      = d_rd;
            reply_left_d = DB_RDATA_LEFT;
          end else begin
            reply_d      = {DB_ACK, 24'h0};
            reply_left_d = '0;
          end
        end else if (busy_timeout) begin
          error_d      = 1'b1;
          reply_d      = {DB_ERR, 24'h0};
          reply_left_d = '0;
          state_d      = S_REPLY;
        end
      end
      S_REPLY: begin
        error_d = rx_valid;
        if (tx_valid_q && tx_ready) begin
          if (reply_left_q == '0) begin
            state_d = S_CMD;
          end else begin
            reply_d      = {reply_q[23:0], 8'h00};
            reply_left_d = reply_left_q - 2'd1;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  // Registered outputs are computed from next state so valid lands one edge after the last byte.
  always_comb begin
    strobe_d   = '0;
    valid_d    = (state_d == S_ISSUE);
    mem_size_d = mem_size_q;
    tx_valid_d = (state_d == S_REPLY);
    if (valid_d) begin
      mem_size_d = size_d;
      unique case (op_d)
        DB_OP_PAUSE:  strobe_d[0] = 1'b1;
        DB_OP_RESUME: strobe_d[1] = 1'b1;
        DB_OP_RESET:  strobe_d[2] = 1'b1;
        DB_OP_MEM_RD: strobe_d[3] = 1'b1;
        DB_OP_MEM_WR: strobe_d[4] = 1'b1;
        DB_OP_REG_RD: strobe_d[5] = 1'b1;
        DB_OP_REG_WR: strobe_d[6] = 1'b1;
        default:      strobe_d    = '0;
      endcase
    end
  end

  assign valid    = valid_q;
  assign pause    = strobe_q[0];
  assign resume   = strobe_q[1];
  assign reset    = strobe_q[2];
  assign mem_rd   = strobe_q[3];
  assign mem_wr   = strobe_q[4];
  assign reg_rd   = strobe_q[5];
  assign reg_wr   = strobe_q[6];
  assign mem_size = mem_size_q;
  assign addr     = addr_q;
  assign d_in     = din_q;
  assign error    = error_q;
  assign tx_data  = reply_q[31:24];
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_db_cmd_decoder.sv
// Table-driven bench for db_cmd_decoder with directed multi-cycle corner sequences.
module tb_db_cmd_decoder;

  // 20-cycle inter-byte timeout, 12-cycle busy watchdog.
  localparam int unsigned CLK_RATE   = 2;
  localparam int unsigned TIMEOUT_US = 10;
  localparam int unsigned BUSY_MAX   = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mcu_busy;
  logic [31:0] d_rd;
  logic        valid, pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr;
  logic [1:0]  mem_size;
  logic [31:0] addr, d_in;
  logic        error;

  db_cmd_decoder #(
    .CLK_RATE   (CLK_RATE),
    .TIMEOUT_US (TIMEOUT_US),
    .BUSY_MAX   (BUSY_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .mcu_busy (mcu_busy),
    .d_rd     (d_rd),
    .valid    (valid),
    .pause    (pause),
    .resume   (resume),
    .reset    (reset),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .reg_rd   (reg_rd),
    .reg_wr   (reg_wr),
    .mem_size (mem_size),
    .addr     (addr),
    .d_in     (d_in),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] frame;   // bytes left-aligned, first byte in [71:64]
    int          nbytes;
    int          gap;     // idle cycles between frame bytes
    int          busy;    // mcu_busy cycles, counted from the valid cycle
    bit          poke;    // inject a stray rx byte while waiting
    logic [31:0] rdata;
    int          exp_valid;
    logic [6:0]  strobe;  // {reg_wr, reg_rd, mem_wr, mem_rd, reset, resume, pause}
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] din;
    int          err;
    int          ntx;
    logic [31:0] tx;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  int          valid_cnt, err_cnt, txn, stray;
  logic [31:0] tx_word;
  logic [6:0]  last_strobe;
  logic [1:0]  last_size;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_strobe = {reg_wr, reg_rd, mem_wr, mem_rd, reset, resume, pause};
      last_size   = mem_size;
    end else if ({reg_wr, reg_rd, mem_wr, mem_rd, reset, resume, pause} != 7'b0) begin
      stray++;
    end
    if (error) err_cnt++;
    if (tx_valid && tx_ready) begin
      txn++;
      tx_word = {tx_word[23:0], tx_data};
    end
  end

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cnt   = 0;
    err_cnt     = 0;
    txn         = 0;
    tx_word     = '0;
    last_strobe = '0;
    last_size   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [71:0] frame, input int nbytes, input int gap,
                              input int busy, input bit poke, input logic [31:0] rdata,
                              input int exp_valid, input logic [6:0] strobe,
                              input logic [1:0] size, input logic [31:0] a,
                              input logic [31:0] din, input int err, input int ntx,
                              input logic [31:0] tx);
    vec_t v;
    v.frame = frame; v.nbytes = nbytes; v.gap = gap; v.busy = busy; v.poke = poke;
    v.rdata = rdata; v.exp_valid = exp_valid; v.strobe = strobe; v.size = size;
    v.addr = a; v.din = din; v.err = err; v.ntx = ntx; v.tx = tx;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    clear_mon();
    d_rd = v.rdata;
    for (int i = 0; i < v.nbytes; i++) begin
      if (i > 0) repeat (v.gap) tick();
      send_byte(v.frame[71-8*i -: 8]);
    end
    if (v.busy > 0) begin
      mcu_busy = 1'b1;
      for (int i = 1; i < v.busy; i++) begin
        if (v.poke && i == 2) begin
          rx_data  = 8'h55;
          rx_valid = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
      end
      tick();
      mcu_busy = 1'b0;
    end
    for (int t = 0; t < 200 && txn < v.ntx; t++) tick();
    repeat (40) tick();
    check({tag, "_valid_cnt"}, 96'(valid_cnt), 96'(v.exp_valid));
    check({tag, "_strobe"},    96'(last_strobe), 96'(v.strobe));
    check({tag, "_mem_size"},  96'(last_size), 96'(v.size));
    check({tag, "_addr"},      96'(addr), 96'(v.addr));
    check({tag, "_d_in"},      96'(d_in), 96'(v.din));
    check({tag, "_err_cnt"},   96'(err_cnt), 96'(v.err));
    check({tag, "_tx_count"},  96'(txn), 96'(v.ntx));
    check({tag, "_tx_bytes"},  96'(tx_word), 96'(v.tx));
  endtask

  vec_t vecs[13];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(72'h01_00000000_00000000, 1, 0, 2, 0, 32'h0, 1, 7'b0000001, 2'd0,
                  32'h0, 32'h0, 0, 1, 32'h000000A5);
    vecs[1]  = mk(72'h24_110C0000_00000000, 5, 0, 3, 0, 32'hDEADBEEF, 1, 7'b0001000, 2'd2,
                  32'h110C0000, 32'h0, 0, 4, 32'hDEADBEEF);
    vecs[2]  = mk(72'h07_00000005_12345678, 9, 0, 2, 0, 32'h0, 1, 7'b1000000, 2'd0,
                  32'h5, 32'h12345678, 0, 1, 32'h000000A5);
    vecs[3]  = mk(72'h09_00000000_00000000, 1, 0, 0, 0, 32'h0, 0, 7'b0, 2'd0,
                  32'h5, 32'h12345678, 1, 1, 32'h000000EE);
    vecs[4]  = mk(72'h16_0000001F_00000000, 5, 15, 1, 0, 32'h0BADF00D, 1, 7'b0100000, 2'd1,
                  32'h1F, 32'h12345678, 0, 4, 32'h0BADF00D);
    vecs[5]  = mk(72'hC1_00000000_00000000, 1, 0, 0, 0, 32'h0, 0, 7'b0, 2'd0,
                  32'h1F, 32'h12345678, 1, 1, 32'h000000EE);
    vecs[6]  = mk(72'h00_00000000_00000000, 1, 0, 0, 0, 32'h0, 0, 7'b0, 2'd0,
                  32'h1F, 32'h12345678, 1, 1, 32'h000000EE);
    vecs[7]  = mk(72'h02_00000000_00000000, 1, 0, 0, 0, 32'h0, 1, 7'b0000010, 2'd0,
                  32'h1F, 32'h12345678, 0, 1, 32'h000000A5);
    vecs[8]  = mk(72'h35_AABBCCDD_01020304, 9, 0, 4, 0, 32'h0, 1, 7'b0010000, 2'd3,
                  32'hAABBCCDD, 32'h01020304, 0, 1, 32'h000000A5);
    // Frame abandoned after one address byte: timeout, no reply.
    vecs[9]  = mk(72'h04_00000000_00000000, 2, 0, 0, 0, 32'h0, 0, 7'b0, 2'd0,
                  32'hBBCCDD00, 32'h01020304, 1, 0, 32'h0);
    vecs[10] = mk(72'h02_00000000_00000000, 1, 0, 2, 0, 32'h0, 1, 7'b0000010, 2'd0,
                  32'hBBCCDD00, 32'h01020304, 0, 1, 32'h000000A5);
    // mcu_busy held past the watchdog.
    vecs[11] = mk(72'h01_00000000_00000000, 1, 0, 40, 0, 32'h0, 1, 7'b0000001, 2'd0,
                  32'hBBCCDD00, 32'h01020304, 1, 1, 32'h000000EE);
    // Stray byte while waiting on the adapter.
    vecs[12] = mk(72'h01_00000000_00000000, 1, 0, 6, 1, 32'h0, 1, 7'b0000001, 2'd0,
                  32'hBBCCDD00, 32'h01020304, 1, 1, 32'h000000A5);

    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    mcu_busy = 1'b0;
    d_rd     = '0;
    clear_mon();
    stray    = 0;
    repeat (3) tick();
    check("reset_outputs",
          {valid, pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr, mem_size, addr, d_in,
           error, tx_valid, tx_data}, 96'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reply held while tx_ready is low.
    clear_mon();
    tx_ready = 1'b0;
    send_byte(8'h01);
    mcu_busy = 1'b1;
    tick();
    mcu_busy = 1'b0;
    for (int t = 0; t < 50 && !tx_valid; t++) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_tx", k), {tx_valid, tx_data}, {1'b1, 8'hA5});
      tick();
    end
    check("hold_no_accept", 96'(txn), 96'd0);
    tx_ready = 1'b1;
    tick();
    check("hold_release_tx_valid", 96'(tx_valid), 96'd0);
    check("hold_accepted", {txn, tx_word}, {32'd1, 32'h000000A5});
    check("hold_strobe", {valid_cnt, 25'd0, last_strobe}, {32'd1, 25'd0, 7'b0000001});
    repeat (5) tick();

    // Asynchronous reset after the third address byte.
    clear_mon();
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {valid, pause, resume, reset, mem_rd, mem_wr, reg_rd, reg_wr, mem_size, addr, d_in,
           error, tx_valid, tx_data}, 96'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("async_reset_no_valid", 96'(valid_cnt), 96'd0);
    run_vec("post_reset", mk(72'h03_00000000_00000000, 1, 0, 2, 0, 32'h0, 1, 7'b0000100, 2'd0,
                             32'h0, 32'h0, 0, 1, 32'h000000A5));

    check("stray_strobes", 96'(stray), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
